dsp_chain_3_fp16_sop2_lane_serializer: RTL and testbench
========================================================

Name: dsp_chain_3_fp16_sop2_lane_serializer

Overview:
- Downstream stage of the 8-instance fp16 sop2 multiplier array.
- Captures each 256-bit result frame (8 lanes x 32 bits) into a small frame FIFO.
- Emits the lanes one per cycle on a 32-bit valid/ready stream, lane 0 first.
- The multiplier array has no backpressure, so frames that arrive while the FIFO is full are dropped and counted.

Parameters:
- LANES, 8, 32-bit lanes per frame.
- LANE_W, 32, bits per lane.
- DEPTH, 2, frame FIFO depth; power of 2, minimum 2.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a valid result frame this cycle.
- in_data  in  LANES*LANE_W  result frame; lane k = bits [k*LANE_W+LANE_W-1 : k*LANE_W].
- in_ready  out  1  FIFO can accept a frame.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  LANE_W  current lane word.
- out_lane  out  $clog2(LANES)  index of the current lane.
- out_last  out  1  current word is lane LANES-1.
- drop_sticky  out  1  set when a frame is dropped; cleared only by reset.
- drop_count  out  CNT_W  saturating count of dropped frames.

Behaviour:
- Reset (async, active-high):
  - FIFO count, read/write pointers and lane index go to 0.
  - out_valid=0, out_lane=0, out_last=0, drop_sticky=0, drop_count=0.
  - in_ready=1 during and after reset.
  - out_data content is don't-care while out_valid=0.
  - FIFO storage is not reset.
- in_ready = (count < DEPTH). It depends only on registered count, never on out_ready. A full FIFO refuses a push even if a pop occurs in the same cycle.
- Push: in_valid && in_ready.
  - Writes in_data at wr_ptr, increments wr_ptr (wraps modulo DEPTH) and count.
- Drop: in_valid && !in_ready.
  - Frame discarded; drop_sticky<=1.
  - drop_count increments and saturates at 2^CNT_W-1.
- out_valid = (count != 0).
  - out_data = lane[lane_idx] of the frame at rd_ptr (combinational read of registered storage).
  - out_lane = lane_idx; out_last = out_valid && (lane_idx == LANES-1).
- Output beat: out_valid && out_ready.
  - lane_idx < LANES-1: lane_idx increments.
  - lane_idx == LANES-1: lane_idx<=0, rd_ptr increments (wraps), count decrements (frame pop).
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
- Stall: while out_valid && !out_ready, out_data, out_lane and out_last hold stable.
- Latency: frame pushed in cycle N gives out_valid=1 in cycle N+1, provided the FIFO was empty.
- Throughput: at most one frame per LANES cycles with out_ready held at 1.
- Frame order is preserved; lanes of a frame are never interleaved with another frame.
- Reset mid-frame: the partial frame and all queued frames are discarded; output restarts at lane 0 of the next pushed frame.

Test Plan:
- Single frame, lanes = 32'h1000_0000+k, out_ready=1 → out_valid cycle after push; 8 beats, out_data 0x10000000..0x10000007, out_lane 0..7, out_last only on beat 8; then out_valid=0.
- Back-to-back frames A,B,C on consecutive cycles, out_ready=0 → A,B accepted, in_ready=0 after B, C dropped. Then drop_sticky=1, drop_count=1. Releasing out_ready yields 16 beats: A lanes then B lanes.
- out_ready toggling 1,0,1,0 during a frame → each lane appears exactly once; out_data and out_lane stable during stalls.
- FIFO full with out_ready=1 on lane 7 of the head frame, and in_valid=1 in the same cycle → push refused, drop_count+1. Next cycle in_ready=1 and count=DEPTH-1.
- 300 frames offered every cycle with out_ready=0 → drop_count saturates at 255, drop_sticky=1, only the first 2 frames are retained.
- Reset asserted asynchronously at lane 3 of a frame with 2 frames queued → out_valid=0 immediately, drop_count=0, in_ready=1. After the next push, output begins at lane 0 of the new frame.

Source files
------------

// File: rtl/dsp_chain_3_fp16_sop2_lane_serializer.sv
// Lane serializer behind the fp16 sop2 multiplier array: buffers whole result
// frames in a small FIFO and streams them out one 32-bit lane per beat.
module dsp_chain_3_fp16_sop2_lane_serializer #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [LANES*LANE_W-1:0]   in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W-1:0]         out_data,
    output logic [$clog2(LANES)-1:0]  out_lane,
    output logic                      out_last,
    output logic                      drop_sticky,
    output logic [CNT_W-1:0]          drop_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = $clog2(LANES);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [LANES*LANE_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W:0]          count_r;
    logic [IDX_W-1:0]        lane_idx_r;
    logic                    drop_sticky_r;
    logic [CNT_W-1:0]        drop_count_r;

    logic                    in_ready_s;
    logic                    out_valid_s;
    logic                    push_s;
    logic                    drop_s;
    logic                    beat_s;
    logic                    pop_s;
    logic                    last_s;
    logic [LANES*LANE_W-1:0] head_frame_s;
    logic [LANE_W-1:0]       out_data_s;

    // Handshake decode; in_ready looks only at the registered count, so a full
    // FIFO refuses a frame even when the head frame retires in the same cycle.
    always_comb begin
        in_ready_s  = (count_r < DEPTH_C);
        out_valid_s = (count_r != '0);
        push_s      = in_valid && in_ready_s;
        drop_s      = in_valid && !in_ready_s;
        beat_s      = out_valid_s && out_ready;
        if (lane_idx_r == LAST_IDX) begin
            last_s = out_valid_s;
        end else begin
            last_s = 1'b0;
        end
        pop_s = beat_s && (lane_idx_r == LAST_IDX);
    end

    // Combinational lane select out of the head frame.
    always_comb begin
        head_frame_s = mem_r[rd_ptr_r];
        out_data_s   = head_frame_s[lane_idx_r*LANE_W +: LANE_W];
    end

    // Frame storage; intentionally not reset, content is qualified by count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers, occupancy and lane sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            lane_idx_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (beat_s) begin
                if (lane_idx_r == LAST_IDX) begin
                    lane_idx_r <= '0;
                end else begin
                    lane_idx_r <= lane_idx_r + IDX_W'(1);
                end
            end
        end
    end

    // Drop bookkeeping: sticky flag and saturating counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_sticky_r <= 1'b0;
            drop_count_r  <= '0;
        end else if (drop_s) begin
            drop_sticky_r <= 1'b1;
            if (drop_count_r != CNT_MAX) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign out_data    = out_data_s;
    assign out_lane    = lane_idx_r;
    assign out_last    = last_s;
    assign drop_sticky = drop_sticky_r;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_dsp_chain_3_fp16_sop2_lane_serializer.sv
// Scoreboard bench for the lane serializer: directed frames, a forked monitor
// pops expected beats whenever the DUT completes an output handshake.
module tb_dsp_chain_3_fp16_sop2_lane_serializer;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [255:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_lane;
    logic         out_last;
    logic         drop_sticky;
    logic [7:0]   drop_count;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  lane;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    dsp_chain_3_fp16_sop2_lane_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_lane    (out_lane),
        .out_last    (out_last),
        .drop_sticky (drop_sticky),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] make_frame(input logic [31:0] base);
        logic [255:0] f;
        for (int k = 0; k < 8; k++) begin
            f[k*32 +: 32] = base + 32'(k);
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] base, input bit accept);
        in_valid = 1'b1;
        in_data  = make_frame(base);
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                sb.push_back('{data: base + 32'(k), lane: 3'(k), last: (k == 7)});
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drain_left"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", out_data, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_lane", 32'(out_lane), 32'(e.lane));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pd;
        logic [2:0]  pl;
        logic        prdy;
        fork
            monitor();
        join_none

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_lane", 32'(out_lane), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_sticky", 32'(drop_sticky), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Single frame, continuous consumer
        out_ready = 1'b1;
        push_frame(32'h1000_0000, 1'b1);
        chk("single_valid_latency", 32'(out_valid), 32'd1);
        chk("single_first_data", out_data, 32'h1000_0000);
        wait_drain("single", 20);
        chk("single_idle", 32'(out_valid), 32'd0);

        // A,B,C back to back with stalled consumer: C dropped
        out_ready = 1'b0;
        push_frame(32'hA000_0000, 1'b1);
        push_frame(32'hB000_0000, 1'b1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        push_frame(32'hC000_0000, 1'b0);
        chk("abc_sticky", 32'(drop_sticky), 32'd1);
        chk("abc_drop_count", 32'(drop_count), 32'd1);
        chk("abc_head_data", out_data, 32'hA000_0000);
        out_ready = 1'b1;
        wait_drain("abc", 40);
        chk("abc_idle", 32'(out_valid), 32'd0);

        // Toggling out_ready: outputs hold during stalls
        out_ready = 1'b0;
        push_frame(32'hD000_0000, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            out_ready = (i % 2 == 0);
            prdy = out_ready;
            pd   = out_data;
            pl   = out_lane;
            step();
            if (!prdy) begin
                chk("stall_data", out_data, pd);
                chk("stall_lane", 32'(out_lane), 32'(pl));
            end
        end
        chk("toggle_left", 32'(sb.size()), 32'd0);
        sb.delete();
        out_ready = 1'b1;
        step();

        // Full FIFO, head at lane 7 retiring, push offered in same cycle
        out_ready = 1'b0;
        push_frame(32'hE000_0000, 1'b1);
        push_frame(32'hF000_0000, 1'b1);
        out_ready = 1'b1;
        repeat (7) step();
        chk("lane7_lane", 32'(out_lane), 32'd7);
        chk("lane7_last", 32'(out_last), 32'd1);
        push_frame(32'h7700_0000, 1'b0);
        chk("popfull_in_ready", 32'(in_ready), 32'd1);
        chk("popfull_drop_count", 32'(drop_count), 32'd2);
        chk("popfull_lane", 32'(out_lane), 32'd0);
        chk("popfull_data", out_data, 32'hF000_0000);
        wait_drain("popfull", 20);
        chk("popfull_idle", 32'(out_valid), 32'd0);

        // 300 frames with no consumer: counter saturates, only 2 kept
        out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            push_frame(32'h6000_0000 + 32'(i << 8), i < 2);
        end
        chk("sat_drop_count", 32'(drop_count), 32'd255);
        chk("sat_sticky", 32'(drop_sticky), 32'd1);
        chk("sat_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait_drain("sat", 40);
        chk("sat_idle", 32'(out_valid), 32'd0);

        // Asynchronous reset at lane 3 with two frames queued
        out_ready = 1'b0;
        push_frame(32'h8000_0000, 1'b1);
        push_frame(32'h9000_0000, 1'b1);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        chk("prereset_lane", 32'(out_lane), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_drop_count", 32'(drop_count), 32'd0);
        chk("areset_in_ready", 32'(in_ready), 32'd1);
        chk("areset_sticky", 32'(drop_sticky), 32'd0);
        chk("areset_lane", 32'(out_lane), 32'd0);
        step();
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        push_frame(32'h5500_0000, 1'b1);
        chk("postreset_lane", 32'(out_lane), 32'd0);
        chk("postreset_data", out_data, 32'h5500_0000);
        wait_drain("postreset", 20);
        chk("postreset_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
